pipelined_func_unit: RTL and testbench
======================================

PIPELINED_FUNC_UNIT -- requirements
Module: pipelined_func_unit

Interface
REQ-001 Parameters: WIDTH, default 16, operand/result width.
REQ-002 Parameters: TAG_W, default 3, reservation-station tag width.
REQ-003 Parameters: MUL_LAT, default 3, multiply latency in cycles; legal range 2..15.
REQ-004 Clock and reset SHALL be as follows: one clock; reset is synchronous and active-high.
REQ-005 Ports, one per line:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous discard of in-flight work.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  unit can accept this cycle.
- op  in  4  opcode.
- tag_in  in  TAG_W  destination tag.
- opa  in  WIDTH  first operand.
- opb  in  WIDTH  second operand.
- cdb_valid  out  1  result on CDB.
- cdb_ready  in  1  CDB grant.
- cdb_tag  out  TAG_W  tag of result.
- cdb_data  out  WIDTH  result.
- cdb_err  out  1  unsupported opcode.
- done_count  out  16  completed-result counter.

Function
REQ-006 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, 1/0), 0110 SHL by opb[3:0], 0111 SHR logical by opb[3:0], 1000 MUL (low WIDTH bits).
REQ-007 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-008 Opcodes 1001..1111 SHALL complete in 1 cycle with cdb_data=0 and cdb_err=1.
REQ-009 Accept SHALL occur when issue_valid && issue_ready; op, tag_in, opa and opb are captured on that edge.
REQ-010 FSM states SHALL be IDLE, BUSY, DONE.
REQ-011 IDLE: on accept of a non-MUL op -> DONE; on accept of MUL -> BUSY; otherwise stay.
REQ-012 BUSY: a down-counter SHALL run for MUL_LAT-1 cycles, then -> DONE; issue_ready=0.
REQ-013 Latency SHALL be: cdb_valid rises 1 cycle after accept for non-MUL ops and MUL_LAT cycles after accept for MUL.
REQ-014 DONE: cdb_valid=1; cdb_tag, cdb_data and cdb_err SHALL hold stable until cdb_ready=1.
REQ-015 DONE with cdb_ready=1: issue_ready=1; a same-cycle accept SHALL go to DONE (non-MUL) or BUSY (MUL), else -> IDLE. Back-to-back throughput is 1 result per cycle.
REQ-016 issue_ready SHALL be combinational from state and cdb_ready: 1 in IDLE, cdb_ready in DONE, 0 in BUSY, and 0 while reset or flush is high.
REQ-017 done_count SHALL increment on each cdb_valid && cdb_ready and wrap from 0xFFFF to 0.
REQ-018 flush SHALL force IDLE on the next edge, deassert cdb_valid and drop any pending result without incrementing done_count.
REQ-019 If flush and cdb_ready are high together in DONE, flush wins: no handshake counted, no accept.
REQ-020 Priority SHALL be reset > flush > handshake/accept.

Reset
REQ-021 Reset SHALL set: state IDLE, cdb_valid 0, cdb_tag 0, cdb_data 0, cdb_err 0, done_count 0, counter 0.
REQ-022 Reset mid-BUSY or mid-DONE SHALL abandon the operation with no CDB output.

Structure
REQ-023 Opcode constants, FSM state encoding and the default WIDTH/TAG_W SHALL live in a shared package fu_pkg.
REQ-024 Combinational single-cycle operations SHALL live in one sub-module, fu_alu_core; MUL, the FSM and the output register stay in pipelined_func_unit.

Verification (WIDTH=16, TAG_W=3, MUL_LAT=3)
REQ-025 ADD opa=0x0005, opb=0x0003, tag=2, cdb_ready=1 -> next cycle cdb_valid=1, cdb_tag=2, cdb_data=0x0008, done_count=1.
REQ-026 SUB 0x0000-0x0001, then SLT 0xFFFF,0x0001 back-to-back with cdb_ready=1 -> 0xFFFF, then 0x0001, on consecutive cycles.
REQ-027 MUL 0x0100*0x0101, tag=5 -> issue_ready=0 for 2 cycles, cdb_data=0x0100 at cycle 3 after accept.
REQ-028 ADD accepted with cdb_ready=0 for 4 cycles -> cdb_valid held, data stable, issue_ready=0, then handshake on cdb_ready=1.
REQ-029 op=1011 -> cdb_err=1, cdb_data=0; flush asserted during MUL BUSY -> no cdb_valid and done_count unchanged.
REQ-030 Reset asserted in DONE -> next cycle all outputs 0; preload done_count 0xFFFF plus one handshake -> 0x0000.

Source files
------------

// File: rtl/fu_pkg.sv
// Shared opcodes, FSM encoding and default widths
// for the pipelined functional unit.
package fu_pkg;

  localparam int FU_WIDTH = 16;
  localparam int FU_TAG_W = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SLT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_MUL = 4'h8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fu_alu_core.sv
// Single-cycle combinational ALU ops; MUL is handled
// by the parent, undefined opcodes raise err.
module fu_alu_core
  import fu_pkg::*;
#(
  parameter int WIDTH = FU_WIDTH
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    res = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt};
      OP_SHL:  res = a << b[3:0];
      OP_SHR:  res = a >> b[3:0];
      OP_MUL:  res = '0;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_func_unit.sv
// Reservation-station functional unit: ALU ops finish
// in one cycle, MUL in MUL_LAT, results held for CDB.
module pipelined_func_unit
  import fu_pkg::*;
#(
  parameter int WIDTH   = FU_WIDTH,
  parameter int TAG_W   = FU_TAG_W,
  parameter int MUL_LAT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       op,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [WIDTH-1:0] cdb_data,
  output logic             cdb_err,
  output logic [15:0]      done_count
);

  // One BUSY cycle per count value, down to zero
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

  state_e           state;
  state_e           state_nx;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_res;
  logic             alu_err;
  logic             accept;
  logic             is_mul;
  logic             hs;

  fu_alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op (op),
    .a  (opa),
    .b  (opb),
    .res(alu_res),
    .err(alu_err)
  );

  assign is_mul    = op == OP_MUL;
  assign cdb_valid = state == S_DONE;
  assign mul_res   = opa_q * opb_q;

  assign issue_ready = !reset && !flush &&
    ((state == S_IDLE) ||
     (state == S_DONE && cdb_ready));

  assign accept = issue_valid && issue_ready;
  assign hs     = cdb_valid && cdb_ready && !flush;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept)
            state_nx = is_mul ? S_BUSY : S_DONE;
        end
        S_BUSY: begin
          if (cnt == 4'd0) state_nx = S_DONE;
        end
        S_DONE: begin
          if (accept)
            state_nx = is_mul ? S_BUSY : S_DONE;
          else if (cdb_ready)
            state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      cdb_err    <= 1'b0;
      done_count <= '0;
    end else begin
      if (hs) done_count <= done_count + 16'd1;
      if (accept) begin
        cdb_tag  <= tag_in;
        cdb_data <= alu_res;
        cdb_err  <= alu_err;
        opa_q    <= opa;
        opb_q    <= opb;
        cnt      <= is_mul ? CNT_INIT : 4'd0;
      end else if (state == S_BUSY && !flush) begin
        if (cnt == 4'd0) cdb_data <= mul_res;
        else             cnt      <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_func_unit.sv
// Directed vector bench for pipelined_func_unit
// (WIDTH=16, TAG_W=3, MUL_LAT=3).
module tb_pipelined_func_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  op;
  logic [2:0]  tag_in;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        cdb_err;
  logic [15:0] done_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  pipelined_func_unit #(
    .WIDTH(16),
    .TAG_W(3),
    .MUL_LAT(3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .op         (op),
    .tag_in     (tag_in),
    .opa        (opa),
    .opb        (opb),
    .cdb_valid  (cdb_valid),
    .cdb_ready  (cdb_ready),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .cdb_err    (cdb_err),
    .done_count (done_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic [3:0]  o,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [2:0]  t,
    input logic [15:0] d,
    input logic        e
  );
    vec_t v;
    v.op = o; v.a = a; v.b = b;
    v.tag = t; v.data = d; v.err = e;
    return v;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(
    input logic [3:0]  o,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [2:0]  t
  );
    issue_valid = 1'b1;
    op = o; opa = a; opb = b; tag_in = t;
  endtask

  // Issue a MUL (ready must be high), walk two BUSY
  // cycles, land in DONE with issue_valid low.
  task automatic mul_op(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [2:0]  t,
    input logic [15:0] exp,
    input bit          from_done
  );
    drive(4'h8, a, b, t);
    chk("mul_accept_ready", 32'(issue_ready), 1);
    step();
    if (from_done) exp_cnt++;
    issue_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("mul_busy_ready", 32'(issue_ready), 0);
      chk("mul_busy_valid", 32'(cdb_valid), 0);
      step();
    end
    chk("mul_valid", 32'(cdb_valid), 1);
    chk("mul_tag", 32'(cdb_tag), 32'(t));
    chk("mul_data", 32'(cdb_data), 32'(exp));
    chk("mul_err", 32'(cdb_err), 0);
  endtask

  initial begin
    vecs[0]  = mk(4'h0, 16'h0005, 16'h0003, 3'd2, 16'h0008, 0);
    vecs[1]  = mk(4'h1, 16'h0000, 16'h0001, 3'd3, 16'hFFFF, 0);
    vecs[2]  = mk(4'h5, 16'hFFFF, 16'h0001, 3'd4, 16'h0001, 0);
    vecs[3]  = mk(4'h2, 16'hF0F0, 16'hFF00, 3'd1, 16'hF000, 0);
    vecs[4]  = mk(4'h3, 16'hF0F0, 16'h0F0F, 3'd7, 16'hFFFF, 0);
    vecs[5]  = mk(4'h4, 16'hAAAA, 16'hFFFF, 3'd6, 16'h5555, 0);
    vecs[6]  = mk(4'h5, 16'h0001, 16'hFFFF, 3'd0, 16'h0000, 0);
    vecs[7]  = mk(4'h6, 16'h0001, 16'h0014, 3'd5, 16'h0010, 0);
    vecs[8]  = mk(4'h7, 16'h8000, 16'h000F, 3'd2, 16'h0001, 0);
    vecs[9]  = mk(4'h0, 16'hFFFF, 16'h0002, 3'd3, 16'h0001, 0);
    vecs[10] = mk(4'hB, 16'h1234, 16'h5678, 3'd4, 16'h0000, 1);
    vecs[11] = mk(4'hF, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0000, 1);
    vecs[12] = mk(4'h5, 16'h8000, 16'h7FFF, 3'd7, 16'h0001, 0);

    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    cdb_ready = 1'b0; op = '0; tag_in = '0;
    opa = '0; opb = '0;
    step(); step();
    chk("rst_valid", 32'(cdb_valid), 0);
    chk("rst_tag", 32'(cdb_tag), 0);
    chk("rst_data", 32'(cdb_data), 0);
    chk("rst_err", 32'(cdb_err), 0);
    chk("rst_count", 32'(done_count), 0);
    chk("rst_ready", 32'(issue_ready), 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", 32'(issue_ready), 1);

    // back-to-back vectors, one result per cycle
    cdb_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      chk("vec_ready", 32'(issue_ready), 1);
      step();
      if (i > 0) exp_cnt++;
      chk($sformatf("vec%0d_valid", i), 32'(cdb_valid), 1);
      chk($sformatf("vec%0d_tag", i), 32'(cdb_tag), 32'(vecs[i].tag));
      chk($sformatf("vec%0d_data", i), 32'(cdb_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_err", i), 32'(cdb_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_count", i), 32'(done_count), 32'(exp_cnt));
    end
    issue_valid = 1'b0;
    step();
    exp_cnt++;
    chk("drain_valid", 32'(cdb_valid), 0);
    chk("drain_count", 32'(done_count), 32'(exp_cnt));

    // MUL from IDLE, then MUL chained from DONE
    mul_op(16'h0100, 16'h0101, 3'd5, 16'h0100, 0);
    mul_op(16'hFFFF, 16'hFFFF, 3'd6, 16'h0001, 1);
    chk("mul_count", 32'(done_count), 32'(exp_cnt));
    step();
    exp_cnt++;
    chk("mul_drain_valid", 32'(cdb_valid), 0);
    chk("mul_drain_count", 32'(done_count), 32'(exp_cnt));

    // CDB stall: result must hold, new issue blocked
    cdb_ready = 1'b0;
    drive(4'h0, 16'h0007, 16'h0009, 3'd1);
    step();
    drive(4'h1, 16'h1111, 16'h0001, 3'd3);
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", 32'(cdb_valid), 1);
      chk("stall_data", 32'(cdb_data), 32'h0010);
      chk("stall_tag", 32'(cdb_tag), 1);
      chk("stall_ready", 32'(issue_ready), 0);
      chk("stall_count", 32'(done_count), 32'(exp_cnt));
      step();
    end
    issue_valid = 1'b0;
    cdb_ready = 1'b1;
    #1;
    chk("release_ready", 32'(issue_ready), 1);
    step();
    exp_cnt++;
    chk("release_valid", 32'(cdb_valid), 0);
    chk("release_count", 32'(done_count), 32'(exp_cnt));

    // flush during MUL BUSY
    drive(4'h8, 16'h0003, 16'h0004, 3'd2);
    step();
    issue_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_busy_ready", 32'(issue_ready), 0);
    step();
    flush = 1'b0;
    #1;
    chk("post_flush_ready", 32'(issue_ready), 1);
    for (int k = 0; k < 3; k++) begin
      chk("flush_busy_valid", 32'(cdb_valid), 0);
      step();
    end
    chk("flush_busy_count", 32'(done_count), 32'(exp_cnt));

    // flush beats cdb_ready and a pending issue in DONE
    drive(4'h3, 16'h00F0, 16'h000F, 3'd4);
    step();
    chk("pre_flush_valid", 32'(cdb_valid), 1);
    flush = 1'b1;
    drive(4'h0, 16'h0001, 16'h0001, 3'd5);
    #1;
    chk("flush_done_ready", 32'(issue_ready), 0);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("flush_done_valid", 32'(cdb_valid), 0);
    chk("flush_done_count", 32'(done_count), 32'(exp_cnt));
    step();
    chk("flush_no_accept", 32'(cdb_valid), 0);

    // reset while holding a result
    drive(4'h4, 16'h1234, 16'h00FF, 3'd6);
    cdb_ready = 1'b0;
    step();
    issue_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_done_valid", 32'(cdb_valid), 0);
    chk("rst_done_tag", 32'(cdb_tag), 0);
    chk("rst_done_data", 32'(cdb_data), 0);
    chk("rst_done_count", 32'(done_count), 0);

    // reset during MUL BUSY
    cdb_ready = 1'b1;
    drive(4'h8, 16'h0002, 16'h0002, 3'd3);
    step();
    issue_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy_valid", 32'(cdb_valid), 0);
      step();
    end

    // done_count wrap: 65536 edges of streaming ADDs
    drive(4'h0, 16'h0001, 16'h0001, 3'd0);
    for (int k = 0; k < 65536; k++) @(posedge clock);
    #1;
    chk("count_ffff", 32'(done_count), 32'hFFFF);
    chk("stream_valid", 32'(cdb_valid), 1);
    step();
    chk("count_wrap", 32'(done_count), 32'h0000);
    issue_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
